// File: rtl/ahb_types_pkg.sv
// ahb_types_pkg: shared AHB-Lite encodings plus transfer size/alignment legality.
package ahb_types_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} transfer_t;
  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} burst_t;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} resp_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} rw_t;
  typedef enum logic [2:0] {BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2} size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  function automatic logic size_ok(input logic [2:0] size, input logic [1:0] lsb);
    return size == WORD ? lsb == 2'b00 : size == HALF ? !lsb[0] : size == BYTE;
  endfunction
endpackage

// File: rtl/ahb_byte_lane_decoder.sv
// ahb_byte_lane_decoder: little-endian byte-lane strobes from transfer size and address LSBs.
module ahb_byte_lane_decoder
  import ahb_types_pkg::*;
(
  input  size_t      size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o
);
  assign strb_o = size_i == WORD ? 4'hF : size_i == HALF ? (addr_i[1] ? 4'hC : 4'h3) : 4'b0001 << addr_i;
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite subordinate backed by a word-organised RAM, with
// configurable OKAY wait states and the two-cycle ERROR response.
module ahb_slave_mem
  import ahb_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  rw_t           rw_q, rw_d;
  size_t         size_q, size_d;
  logic [31:0]   mem [WORDS];
  logic [3:0]    strb;
  logic          acc, legal, done;
  logic          unused_burst;

  assign unused_burst = ^HBURST;
  assign HREADYOUT = state_q == ST_WAIT ? cnt_q == 4'd0 : state_q != ST_ERR1;
  assign HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2) ? ERROR : OKAY;
  // pend_q marks a zero-wait data phase sitting in IDLE
  assign done = state_q == ST_IDLE ? pend_q : state_q == ST_WAIT && cnt_q == 4'd0;
  assign acc = HREADYOUT && HSEL && HREADY && (HTRANS == NONSEQ || HTRANS == SEQ);
  assign legal = {1'b0, HADDR} < (ADDR_W + 1)'(MEM_BYTES) && size_ok(HSIZE, HADDR[1:0]);
  assign HRDATA = done && rw_q == READ ? mem[addr_q[AW-1:2]] : '0;

  ahb_byte_lane_decoder u_lanes (
    .size_i(size_q),
    .addr_i(addr_q[1:0]),
    .strb_o(strb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    if (state_q == ST_ERR1) state_d = ST_ERR2;
    else if (state_q == ST_WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    else begin
      state_d = !acc ? ST_IDLE : !legal ? ST_ERR1 : WS == 4'd0 ? ST_IDLE : ST_WAIT;
      pend_d  = acc && legal && WS == 4'd0;
      cnt_d   = WS;
      if (acc) begin
        addr_d = HADDR[AW-1:0];
        rw_d   = rw_t'(HWRITE);
        size_d = size_t'(HSIZE);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      rw_q    <= READ;
      size_q  <= BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
    end
  end

  // done is forced low by the async reset, so a pending write is dropped
  always_ff @(posedge HCLK) begin
    if (done && rw_q == WRITE)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
  end
endmodule
